// File: rtl/dot_acc.sv
// Pipelined signed dot-product engine: LANES multipliers, registered adder tree,
// and a packet accumulator that emits one (optionally saturated) sum per ilast beat.
module dot_acc #(
    parameter int LANES  = 8,
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 32,
    parameter int SAT    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES*IWIDTH-1:0]    vec0,
    input  logic [LANES*IWIDTH-1:0]    vec1,
    input  logic                       ivalid,
    input  logic                       ilast,
    output logic signed [OWIDTH-1:0]   result,
    output logic                       ovalid,
    output logic                       ovf
);

    localparam int LG    = $clog2(LANES);
    localparam int PW    = 2 * IWIDTH;
    localparam int TW    = PW + LG;
    localparam int NODES = 2 * LANES - 1;
    localparam int DEPTH = LG + 2;

    function automatic logic signed [TW-1:0] mul_ext(input logic signed [IWIDTH-1:0] a,
                                                     input logic signed [IWIDTH-1:0] b);
        logic signed [PW-1:0] p;
        p = a * b;
        return {{LG{p[PW-1]}}, p};
    endfunction

    function automatic logic signed [OWIDTH-1:0] clamp(input logic signed [OWIDTH:0] s);
        if (s[OWIDTH] == s[OWIDTH-1])
            return s[OWIDTH-1:0];
        else if (SAT != 0)
            return s[OWIDTH] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}};
        else
            return s[OWIDTH-1:0];
    endfunction

    // Stage 0: input registers
    logic [LANES*IWIDTH-1:0] a_p0_q, b_p0_q;
    always_ff @(posedge clk) begin
        a_p0_q <= vec0;
        b_p0_q <= vec1;
    end

    // Stage 1 and tree levels: heap-ordered nodes, leaves hold products, node 0 is the root
    logic signed [TW-1:0] node_q [NODES];
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            node_q[LANES-1+i] <= mul_ext(a_p0_q[i*IWIDTH +: IWIDTH], b_p0_q[i*IWIDTH +: IWIDTH]);
        for (int k = 0; k < LANES-1; k++)
            node_q[k] <= node_q[2*k+1] + node_q[2*k+2];
    end

    logic [DEPTH-1:0] vld_q, lst_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= {vld_q[DEPTH-2:0], ivalid};
            lst_q <= {lst_q[DEPTH-2:0], ivalid & ilast};
        end
    end

    // Final stage: accumulate at OWIDTH+1 bits, then clamp or wrap
    logic signed [OWIDTH-1:0] acc_q, clip_d;
    logic signed [OWIDTH:0]   base_d, sum_d;
    logic                     first_q, ovf_acc_q, step_ovf_d;

    always_comb begin
        base_d     = first_q ? '0 : {acc_q[OWIDTH-1], acc_q};
        sum_d      = base_d + {{(OWIDTH+1-TW){node_q[0][TW-1]}}, node_q[0]};
        step_ovf_d = sum_d[OWIDTH] ^ sum_d[OWIDTH-1];
        clip_d     = clamp(sum_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q     <= '0;
            first_q   <= 1'b1;
            ovf_acc_q <= 1'b0;
            result    <= '0;
            ovalid    <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            ovalid <= 1'b0;
            if (vld_q[DEPTH-1]) begin
                if (lst_q[DEPTH-1]) begin
                    result    <= clip_d;
                    ovf       <= ovf_acc_q | step_ovf_d;
                    ovalid    <= 1'b1;
                    acc_q     <= '0;
                    first_q   <= 1'b1;
                    ovf_acc_q <= 1'b0;
                end else begin
                    acc_q     <= clip_d;
                    first_q   <= 1'b0;
                    ovf_acc_q <= ovf_acc_q | step_ovf_d;
                end
            end
        end
    end

endmodule

// File: doc/dot_acc.md
Name: dot_acc

Overview:
- Parametrised, fully pipelined signed dot-product engine with LANES multiplier lanes and a registered binary adder tree.
- Adds a packet accumulator: consecutive valid beats are summed until a beat flagged ilast, then one result is emitted.
- Long vectors stream through the block in LANES-wide chunks. This serves the lab datapath that consumes matrix rows wider than one beat.
- Optional saturating arithmetic with a per-result overflow flag.

Parameters:
- LANES, 8, number of element pairs per beat; power of two, >= 2.
- IWIDTH, 8, signed element width.
- OWIDTH, 32, signed result/accumulator width; must be >= 2*IWIDTH + log2(LANES).
- SAT, 1, 1 = saturate accumulator to OWIDTH signed range; 0 = two's-complement wrap.

Ports:
- clk  input  1  rising-edge clock; only clock.
- rst  input  1  synchronous, active-low reset; sampled on rising clk.
- vec0  input  LANES*IWIDTH  signed elements; lane i at [i*IWIDTH +: IWIDTH].
- vec1  input  LANES*IWIDTH  signed elements, same packing.
- ivalid  input  1  beat valid; vec0/vec1/ilast sampled when high.
- ilast  input  1  marks final beat of a packet; ignored when ivalid low.
- result  output  OWIDTH  signed packet dot product; held until next ovalid.
- ovalid  output  1  single-cycle pulse per completed packet.
- ovf  output  1  high with ovalid if any accumulate step of that packet exceeded OWIDTH range.

Behaviour:
- Reset (rst == 0 at a rising edge):
  - result, ovalid and ovf = 0; all pipeline valid/last bits = 0.
  - Accumulator cleared; the first-beat flag is set.
- Pipeline: no backpressure; one beat accepted per cycle.
  - Stage 0: register the inputs, ivalid and ilast.
  - Stage 1: LANES signed products, each 2*IWIDTH bits.
  - Stages 2 .. 1+log2(LANES): adder tree levels. Each level widens by 1 bit and sign-extends; no overflow is possible inside the tree.
  - Final stage: accumulate and output register.
- Latency: LAT = log2(LANES) + 3 rising edges, counting the sampling edge as edge 1 (6 for LANES = 8). ovalid rises after edge LAT of the ilast beat.
- valid and last travel in a shift chain alongside the data. Bubbles (ivalid low) do not affect the accumulator.
- Accumulate step, for each valid tree output T:
  - S = (first ? 0 : acc) + sign-extended T, computed at OWIDTH+1 bits.
  - Out of OWIDTH range with SAT = 1: clamp to +2^(OWIDTH-1)-1 or -2^(OWIDTH-1).
  - Out of range with SAT = 0: keep the low OWIDTH bits.
  - Either way, set sticky ovf_acc.
  - Not last: acc <= S; first <= 0; ovf_acc accumulates.
  - Last: result <= S; ovf <= ovf_acc | this step's overflow; ovalid <= 1; then acc <= 0, first <= 1, ovf_acc <= 0.
- A single-beat packet is ivalid and ilast both high on the same beat.
- ovalid is deasserted on every cycle without a completing last beat. result and ovf hold their values between pulses.
- Back-to-back packets: a last beat followed immediately by a new first beat must not cross-accumulate. Result pulses can occur on consecutive cycles.
- Reset mid-packet: partial sums and all in-flight beats are discarded. No ovalid may appear after reset for beats sampled before it.
- ilast with ivalid low: no effect.

Test Plan:
- Single beat, LANES=8 defaults: vec0 lanes = 1..8, vec1 all 1, ivalid=ilast=1 for one cycle -> result = 36, ovf = 0, ovalid high exactly one cycle, 6 edges after sampling.
- 3-beat packet with a 1-cycle bubble between beats 1 and 2: each beat has vec0 all 2, vec1 all 3, ilast on beat 3 -> single ovalid, result = 144; no ovalid on beats 1 and 2.
- Negative values: vec0 all -128, vec1 all 127, single beat -> result = -130048, ovf = 0.
- OWIDTH=20, SAT=1: 4-beat packet, all lanes -128 * -128 (131072 per beat) -> result = 524287, ovf = 1. Same stimulus with SAT=0 -> result = -524288, ovf = 1. Following 1-beat packet of value 36 -> result 36, ovf = 0.
- Back-to-back: 4 consecutive beats, ilast=1 on each, with values 36, 0, -8, 144 -> ovalid high 4 consecutive cycles with results 36, 0, -8, 144 in order.
- Reset mid-packet: 2 beats of 36 without ilast, then rst = 0 for one cycle during the pipeline fill, then 1-beat packet of 36 -> exactly one ovalid after reset, result = 36.
